// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one four-phase memory port between a CPU and a DMA requester.
// A watchdog completes (and sticky-flags) any access the memory never acknowledges.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_en,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_mfc,
    input  logic          dma_en,
    input  logic          dma_rw,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_mfc,
    output logic          mem_enable,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_mfc,
    output logic          owner,
    output logic          timeout_err
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_grant_reg, last_grant_next;
    logic          mem_enable_reg, mem_enable_next;
    logic          mem_rw_reg, mem_rw_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          timeout_err_reg, timeout_err_next;
    logic          mfc_reg [2];
    logic          mfc_next [2];
    logic [DW-1:0] rdata_reg [2];
    logic [DW-1:0] rdata_next [2];

    // Requester 0 is the CPU, requester 1 the DMA engine.
    logic [1:0]    req_en;
    logic [1:0]    req_rw;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_wdata [2];
    logic          winner;

    assign req_en       = {dma_en, cpu_en};
    assign req_rw       = {dma_rw, cpu_rw};
    assign req_addr[0]  = cpu_addr;
    assign req_addr[1]  = dma_addr;
    assign req_wdata[0] = cpu_wdata;
    assign req_wdata[1] = dma_wdata;

    // On a tie the requester not served last wins; otherwise the lone requester wins.
    always_comb begin
        if (req_en == 2'b11) winner = ~last_grant_reg;
        else                 winner = req_en[1];
    end

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        last_grant_next  = last_grant_reg;
        mem_enable_next  = mem_enable_reg;
        mem_rw_next      = mem_rw_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        cnt_next         = cnt_reg;
        timeout_err_next = timeout_err_reg;
        for (int i = 0; i < 2; i++) begin
            mfc_next[i]   = mfc_reg[i];
            rdata_next[i] = rdata_reg[i];
        end
        unique case (state_reg)
            IDLE: begin
                if (|req_en) begin
                    mem_enable_next = 1'b1;
                    mem_rw_next     = req_rw[winner];
                    mem_addr_next   = req_addr[winner];
                    mem_wdata_next  = req_wdata[winner];
                    owner_next      = winner;
                    last_grant_next = winner;
                    cnt_next        = '0;
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_mfc) begin
                    rdata_next[owner_reg] = mem_rdata;
                    mfc_next[owner_reg]   = 1'b1;
                    mem_enable_next       = 1'b0;
                    state_next            = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next[owner_reg] = '0;
                    mfc_next[owner_reg]   = 1'b1;
                    mem_enable_next       = 1'b0;
                    timeout_err_next      = 1'b1;
                    state_next            = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // Both sides of the handshake must have released, which also absorbs a late mfc.
                if (!req_en[owner_reg] && !mem_mfc) begin
                    mfc_next[owner_reg] = 1'b0;
                    state_next          = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            mem_enable_reg  <= 1'b0;
            mem_rw_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            last_grant_reg  <= last_grant_next;
            mem_enable_reg  <= mem_enable_next;
            mem_rw_reg      <= mem_rw_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            cnt_reg         <= cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            always_ff @(posedge clock) begin
                if (reset) begin
                    mfc_reg[gi]   <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    mfc_reg[gi]   <= mfc_next[gi];
                    rdata_reg[gi] <= rdata_next[gi];
                end
            end
        end
    endgenerate

    assign cpu_mfc     = mfc_reg[0];
    assign dma_mfc     = mfc_reg[1];
    assign cpu_rdata   = rdata_reg[0];
    assign dma_rdata   = rdata_reg[1];
    assign mem_enable  = mem_enable_reg;
    assign mem_rw      = mem_rw_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign owner       = owner_reg;
    assign timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomised checks of mem_port_arbiter against a transaction-level model
// of the shared port, driven by a behavioural four-phase memory with variable latency.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0, cpu_rw = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_mfc;
    logic        dma_en = 1'b0, dma_rw = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic [15:0] dma_rdata;
    logic        dma_mfc;
    logic        mem_enable, mem_rw;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_mfc = 1'b0;
    logic        owner, timeout_err;

    mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_mfc(cpu_mfc),
        .dma_en(dma_en), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_mfc(dma_mfc),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_mfc(mem_mfc),
        .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Memory: answers mfc a programmable number of cycles after seeing enable, drops it after enable falls.
    logic [15:0] mem_arr [0:255];
    int  mem_cnt = 0;
    int  rand_delay = 3;
    int  mem_delay = 3;
    bit  mem_dead = 1'b0;
    bit  rand_mode = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 5) ? 16'h1234 : 16'(i * 257);
            mem_mfc <= 1'b0;
            mem_cnt <= 0;
        end else if (mem_enable && !mem_mfc) begin
            mem_cnt <= mem_cnt + 1;
            if (!mem_dead && (mem_cnt + 1 >= (rand_mode ? rand_delay : mem_delay))) begin
                if (mem_rw) begin
                    mem_arr[mem_addr[7:0]] <= mem_wdata;
                    mem_rdata              <= mem_wdata;
                end else begin
                    mem_rdata <= mem_arr[mem_addr[7:0]];
                end
                mem_mfc <= 1'b1;
            end
        end else if (!mem_enable) begin
            mem_mfc    <= 1'b0;
            mem_cnt    <= 0;
            rand_delay <= int'($urandom_range(1, 10));
        end
    end

    // Reference model: one outstanding grant; it is answered by mfc or after TMO cycles of enable,
    // and released once the owner and the memory have both let go.
    bit          m_started = 1'b0;
    bit          m_busy = 1'b0, m_answered = 1'b0, m_last = 1'b1;
    int          m_en_cycles = 0;
    logic        e_en = 1'b0, e_rw = 1'b0, e_owner = 1'b0, e_terr = 1'b0;
    logic [15:0] e_addr = '0, e_wdata = '0;
    logic        e_mfc [2];
    logic [15:0] e_rdata [2];

    function automatic bit pick();
        if (cpu_en && dma_en) return !m_last;
        return dma_en;
    endfunction

    always @(posedge clock) begin
        m_started <= 1'b1;
        if (reset) begin
            m_busy <= 1'b0; m_answered <= 1'b0; m_last <= 1'b1; m_en_cycles <= 0;
            e_en <= 1'b0; e_rw <= 1'b0; e_owner <= 1'b0; e_terr <= 1'b0;
            e_addr <= '0; e_wdata <= '0;
            e_mfc[0] <= 1'b0; e_mfc[1] <= 1'b0; e_rdata[0] <= '0; e_rdata[1] <= '0;
        end else if (!m_busy) begin
            if (cpu_en || dma_en) begin
                m_busy      <= 1'b1;
                m_answered  <= 1'b0;
                m_en_cycles <= 1;
                m_last      <= pick();
                e_owner     <= pick();
                e_en        <= 1'b1;
                e_rw        <= pick() ? dma_rw : cpu_rw;
                e_addr      <= pick() ? dma_addr : cpu_addr;
                e_wdata     <= pick() ? dma_wdata : cpu_wdata;
            end
        end else if (!m_answered) begin
            if (mem_mfc) begin
                e_rdata[e_owner] <= mem_rdata;
                e_mfc[e_owner]   <= 1'b1;
                e_en             <= 1'b0;
                m_answered       <= 1'b1;
            end else if (m_en_cycles == TMO) begin
                e_rdata[e_owner] <= '0;
                e_mfc[e_owner]   <= 1'b1;
                e_en             <= 1'b0;
                e_terr           <= 1'b1;
                m_answered       <= 1'b1;
            end else begin
                m_en_cycles <= m_en_cycles + 1;
            end
        end else if (!(e_owner ? dma_en : cpu_en) && !mem_mfc) begin
            e_mfc[e_owner] <= 1'b0;
            m_busy         <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (m_started) begin
            chk("mem_enable", 32'(mem_enable), 32'(e_en));
            chk("mem_rw", 32'(mem_rw), 32'(e_rw));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("owner", 32'(owner), 32'(e_owner));
            chk("timeout_err", 32'(timeout_err), 32'(e_terr));
            chk("cpu_mfc", 32'(cpu_mfc), 32'(e_mfc[0]));
            chk("dma_mfc", 32'(dma_mfc), 32'(e_mfc[1]));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata[0]));
            chk("dma_rdata", 32'(dma_rdata), 32'(e_rdata[1]));
        end
    end

    // Monitors: cycle count, grant history, enable and cpu_mfc high-run lengths.
    int   cyc = 0;
    int   g_count = 0;
    logic grant_owner [0:1023];
    int   grant_cyc [0:1023];
    logic prev_en = 1'b0;
    int   en_run = 0, last_en_run = 0;
    int   cmfc_run = 0, last_cmfc_run = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        prev_en <= mem_enable;
        if (mem_enable && !prev_en && g_count < 1024) begin
            grant_owner[g_count] <= owner;
            grant_cyc[g_count]   <= cyc;
            g_count              <= g_count + 1;
        end
        if (mem_enable) en_run <= en_run + 1;
        else begin
            if (en_run != 0) last_en_run <= en_run;
            en_run <= 0;
        end
        if (cpu_mfc) cmfc_run <= cmfc_run + 1;
        else begin
            if (cmfc_run != 0) last_cmfc_run <= cmfc_run;
            cmfc_run <= 0;
        end
    end

    int cpu_drop_cyc = 0;

    task automatic wait_mfc(input bit who, input bit level, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if ((who ? dma_mfc : cpu_mfc) === level) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic do_req(input bit who, input bit rw, input logic [15:0] addr,
                          input logic [15:0] data, input int hold, output logic [15:0] rd);
        @(negedge clock);
        if (who) begin dma_rw = rw; dma_addr = addr; dma_wdata = data; dma_en = 1'b1; end
        else     begin cpu_rw = rw; cpu_addr = addr; cpu_wdata = data; cpu_en = 1'b1; end
        wait_mfc(who, 1'b1, who ? "dma_mfc_rise" : "cpu_mfc_rise");
        rd = who ? dma_rdata : cpu_rdata;
        repeat (hold) @(negedge clock);
        if (who) dma_en = 1'b0;
        else begin cpu_en = 1'b0; cpu_drop_cyc = cyc; end
        wait_mfc(who, 1'b0, who ? "dma_mfc_fall" : "cpu_mfc_fall");
        $display("[TB] %s %s addr=%04h wdata=%04h rdata=%04h hold=%0d", who ? "dma" : "cpu",
                 rw ? "wr" : "rd", addr, data, rd, hold);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd, rd2;
        int base;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_cpu_mfc", 32'(cpu_mfc), 32'd0);
        reset = 1'b0;

        // CPU-only read with a 3-cycle memory
        @(negedge clock);
        cpu_rw = 1'b0; cpu_addr = 16'h0005; cpu_en = 1'b1;
        @(negedge clock);
        chk("rd_latency_mem_enable", 32'(mem_enable), 32'd1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0005);
        wait_mfc(1'b0, 1'b1, "rd_cpu_mfc");
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        chk("rd_dma_mfc", 32'(dma_mfc), 32'd0);
        cpu_en = 1'b0;
        wait_mfc(1'b0, 1'b0, "rd_cpu_release");
        chk("rd_enable_cycles", 32'(last_en_run), 32'd4);
        $display("[TB] cpu rd addr=0005 rdata=%04h", cpu_rdata);

        // DMA write
        do_req(1'b1, 1'b1, 16'h00F0, 16'hBEEF, 0, rd);
        chk("wr_mem_array", 32'(mem_arr[8'hF0]), 32'hBEEF);
        chk("wr_owner", 32'(owner), 32'd1);
        chk("wr_mem_rw", 32'(mem_rw), 32'd1);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);

        // Simultaneous requests after reset, then continuous contention
        do_reset();
        base = g_count;
        fork
            for (int k = 0; k < 3; k++) begin
                logic [15:0] r;
                do_req(1'b0, 1'b0, 16'(16'h20 + k), 16'h0, 0, r);
            end
            for (int k = 0; k < 3; k++) begin
                logic [15:0] r;
                do_req(1'b1, 1'b1, 16'(16'h28 + k), 16'(16'hA000 + k), 0, r);
            end
        join
        for (int k = 0; k < 6; k++)
            chk("rr_grant_order", 32'(grant_owner[base + k]), 32'(k % 2));

        // Timeout with a dead memory, then sticky flag through good accesses
        mem_dead = 1'b1;
        do_req(1'b0, 1'b0, 16'h0005, 16'h0, 0, rd);
        chk("tmo_cpu_rdata", 32'(rd), 32'd0);
        chk("tmo_enable_cycles", 32'(last_en_run), 32'(TMO));
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        mem_dead = 1'b0;
        do_req(1'b1, 1'b1, 16'h0040, 16'h5555, 0, rd);
        do_req(1'b0, 1'b0, 16'h0040, 16'h0, 0, rd);
        chk("tmo_readback", 32'(rd), 32'h5555);
        chk("tmo_flag_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of an access
        mem_delay = 6;
        @(negedge clock);
        cpu_rw = 1'b0; cpu_addr = 16'h0005; cpu_en = 1'b1;
        @(negedge clock);
        chk("rmid_mem_enable_before", 32'(mem_enable), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rmid_mem_enable", 32'(mem_enable), 32'd0);
        chk("rmid_cpu_mfc", 32'(cpu_mfc), 32'd0);
        chk("rmid_dma_mfc", 32'(dma_mfc), 32'd0);
        chk("rmid_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0; cpu_en = 1'b0; mem_delay = 3;
        do_req(1'b0, 1'b0, 16'h0005, 16'h0, 0, rd);
        chk("rmid_fresh_read", 32'(rd), 32'h1234);

        // Owner drops enable during the access: mfc is still pulsed
        @(negedge clock);
        cpu_rw = 1'b0; cpu_addr = 16'h0006; cpu_en = 1'b1;
        repeat (2) @(negedge clock);
        cpu_en = 1'b0;
        wait_mfc(1'b0, 1'b1, "viol_cpu_mfc");
        chk("viol_cpu_rdata", 32'(cpu_rdata), 32'h0606);
        wait_mfc(1'b0, 1'b0, "viol_cpu_release");
        $display("[TB] cpu rd addr=0006 (early drop) rdata=%04h", cpu_rdata);

        // Slow release with a pending DMA request
        fork
            do_req(1'b0, 1'b0, 16'h0005, 16'h0, 5, rd);
            begin
                repeat (2) @(negedge clock);
                do_req(1'b1, 1'b1, 16'h0030, 16'h7777, 0, rd2);
            end
        join
        chk("slow_cpu_mfc_cycles", 32'(last_cmfc_run), 32'd6);
        chk("slow_dma_owner", 32'(grant_owner[g_count - 1]), 32'd1);
        chk("slow_dma_grant_delay", 32'(grant_cyc[g_count - 1] - cpu_drop_cyc), 32'd2);

        // Randomised contention with random memory latency (some beyond the watchdog)
        rand_mode = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                logic [15:0] r;
                repeat ($urandom_range(0, 3)) @(negedge clock);
                do_req(1'b0, 1'($urandom_range(0, 1)), 16'(16'h20 + $urandom_range(0, 31)),
                       16'($urandom), int'($urandom_range(0, 3)), r);
            end
            for (int k = 0; k < 30; k++) begin
                logic [15:0] r;
                repeat ($urandom_range(0, 3)) @(negedge clock);
                do_req(1'b1, 1'($urandom_range(0, 1)), 16'(16'h20 + $urandom_range(0, 31)),
                       16'($urandom), int'($urandom_range(0, 3)), r);
            end
        join
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
